// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, index width helper and default memory map
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } bus_state_t;

    // A single-region map still needs a 1-bit index register.
    function automatic int region_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [31:0] ROM_BASE = 32'h0000_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0000_1000;
    localparam logic [31:0] RAM_BASE = 32'h0000_1000;
    localparam logic [31:0] RAM_SIZE = 32'h0000_1000;
    localparam logic [3:0]  ROM_WAIT = 4'd0;
    localparam logic [3:0]  RAM_WAIT = 4'd1;

endpackage

// File: rtl/addr_region_match.sv
// rtl/addr_region_match.sv - single address window compare and offset generation
module addr_region_match
    import bus_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    logic [ADDR_W:0] addr_x;
    logic [ADDR_W:0] lo_x;
    logic [ADDR_W:0] hi_x;

    // One extra bit lets a window end exactly at the top of the address space.
    assign addr_x = {1'b0, addr};
    assign lo_x   = {1'b0, base};
    assign hi_x   = {1'b0, base} + {1'b0, size};
    assign hit    = (addr_x >= lo_x) && (addr_x < hi_x);
    assign offset = addr - base;

endmodule

// File: rtl/mem_bus_decoder.sv
// rtl/mem_bus_decoder.sv - CPU bus decoder with per-region wait states; MEM_BUS_FAULT_LOG_EN adds fault logging
module mem_bus_decoder
    import bus_pkg::*;
#(
    parameter int NUM_REGIONS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int WAIT_W      = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {RAM_BASE, ROM_BASE},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {RAM_SIZE, ROM_SIZE},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT = {RAM_WAIT, ROM_WAIT}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [ADDR_W-1:0]             addr,
    input  logic                          we,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          ready,
    output logic                          fault,
    output logic [NUM_REGIONS-1:0]        s_sel,
    output logic [ADDR_W-1:0]             s_addr,
    output logic                          s_we,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic [NUM_REGIONS*DATA_W-1:0] s_rdata
`ifdef MEM_BUS_FAULT_LOG_EN
    ,
    output logic [ADDR_W-1:0]             fault_addr,
    output logic [15:0]                   fault_count
`endif
);

    localparam int IDX_W = region_idx_w(NUM_REGIONS);

    bus_state_t state, state_nxt;

    logic [NUM_REGIONS-1:0] hit_vec;
    logic [ADDR_W-1:0]      off_arr  [NUM_REGIONS];
    logic [DATA_W-1:0]      rd_arr   [NUM_REGIONS];
    logic [WAIT_W-1:0]      wait_arr [NUM_REGIONS];

    logic             any_hit;
    logic [IDX_W-1:0] hit_idx;
    logic             accept;
    logic             enter_fault;

    logic [IDX_W-1:0]  idx_q;
    logic [ADDR_W-1:0] off_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [WAIT_W-1:0] cnt_q;
    logic [DATA_W-1:0] rdata_q;

    for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
        addr_region_match #(.ADDR_W(ADDR_W)) u_match (
            .addr   (addr),
            .base   (REGION_BASE[g*ADDR_W +: ADDR_W]),
            .size   (REGION_SIZE[g*ADDR_W +: ADDR_W]),
            .hit    (hit_vec[g]),
            .offset (off_arr[g])
        );
        assign rd_arr[g]   = s_rdata[g*DATA_W +: DATA_W];
        assign wait_arr[g] = REGION_WAIT[g*WAIT_W +: WAIT_W];
    end

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        enter_fault = 1'b0;
        ready       = 1'b0;
        fault       = 1'b0;
        rdata       = rdata_q;
        s_sel       = '0;
        s_addr      = '0;
        s_we        = 1'b0;
        s_wdata     = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (any_hit) begin
                        accept    = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        enter_fault = 1'b1;
                        state_nxt   = FAULT;
                    end
                end
            end
            ACCESS: begin
                s_sel   = NUM_REGIONS'(1) << idx_q;
                s_addr  = off_q;
                s_wdata = wdata_q;
                if (cnt_q == '0) begin
                    s_we      = we_q;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            FAULT: begin
                ready     = 1'b1;
                fault     = 1'b1;
                rdata     = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q   <= hit_idx;
                off_q   <= off_arr[hit_idx];
                we_q    <= we;
                wdata_q <= wdata;
                cnt_q   <= wait_arr[hit_idx];
            end else if (state == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state == ACCESS && cnt_q == '0 && !we_q) begin
                rdata_q <= rd_arr[idx_q];
            end
        end
    end

`ifdef MEM_BUS_FAULT_LOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_addr  <= '0;
            fault_count <= '0;
        end else if (enter_fault) begin
            fault_addr <= addr;
            if (fault_count != 16'hFFFF) begin
                fault_count <= fault_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb/tb_mem_bus_decoder.sv - directed self-checking bench for mem_bus_decoder
module tb_mem_bus_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [31:0] addr;
    logic [7:0]  wdata, rdata, s_wdata;
    logic        ready, fault, s_we;
    logic [1:0]  s_sel;
    logic [31:0] s_addr;
    logic [15:0] s_rdata;

    logic        req_o, we_o;
    logic [31:0] addr_o, s_addr_o;
    logic [7:0]  wdata_o, rdata_o, s_wdata_o;
    logic        ready_o, fault_o, s_we_o;
    logic [1:0]  s_sel_o;
    logic [15:0] s_rdata_o;

`ifdef MEM_BUS_FAULT_LOG_EN
    logic [31:0] fault_addr, fault_addr_o;
    logic [15:0] fault_count, fault_count_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_decoder dut (
        .clk(clk), .rst(rst), .req(req), .addr(addr), .we(we), .wdata(wdata),
        .rdata(rdata), .ready(ready), .fault(fault), .s_sel(s_sel),
        .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata), .s_rdata(s_rdata)
`ifdef MEM_BUS_FAULT_LOG_EN
        , .fault_addr(fault_addr), .fault_count(fault_count)
`endif
    );

    mem_bus_decoder #(
        .REGION_BASE({32'h0000_0000, 32'h0000_0000}),
        .REGION_SIZE({32'h0000_1000, 32'h0000_1000}),
        .REGION_WAIT(8'h00)
    ) dut_ovl (
        .clk(clk), .rst(rst), .req(req_o), .addr(addr_o), .we(we_o), .wdata(wdata_o),
        .rdata(rdata_o), .ready(ready_o), .fault(fault_o), .s_sel(s_sel_o),
        .s_addr(s_addr_o), .s_we(s_we_o), .s_wdata(s_wdata_o), .s_rdata(s_rdata_o)
`ifdef MEM_BUS_FAULT_LOG_EN
        , .fault_addr(fault_addr_o), .fault_count(fault_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with the DUT idle; returns one idle cycle after ready.
    task automatic access(input logic [31:0] a, input logic w, input logic [7:0] d,
                          output int lat, output logic [1:0] sel1, output logic [31:0] saddr1,
                          output logic flt, output logic [7:0] rd,
                          output int we_cnt, output int we_cyc);
        lat = -1; sel1 = '0; saddr1 = '0; flt = 1'b0; rd = '0; we_cnt = 0; we_cyc = 0;
        req = 1'b1; addr = a; we = w; wdata = d;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                sel1   = s_sel;
                saddr1 = s_addr;
            end
            if (s_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (ready) begin
                lat = c;
                flt = fault;
                rd  = rdata;
                break;
            end
        end
        req = 1'b0;
        @(negedge clk);
    endtask

    int          lat, wcnt, wcyc, nrdy, t1, t2;
    logic [1:0]  sel1;
    logic [31:0] sa1;
    logic        flt;
    logic [7:0]  rd;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        req_o = 1'b0; addr_o = '0; we_o = 1'b0; wdata_o = '0;
        s_rdata = {8'h5A, 8'hA5};
        s_rdata_o = {8'h66, 8'h99};
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_fault", fault, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_swe", s_we, 0);
        rst = 1'b1;
        @(negedge clk);

        // read region 0, no wait states
        access(32'h0000_0010, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("rd0_lat", lat, 2);
        chk("rd0_sel", sel1, 2'b01);
        chk("rd0_saddr", sa1, 32'h10);
        chk("rd0_rdata", rd, 8'hA5);
        chk("rd0_fault", flt, 0);
        chk("rd0_we", wcnt, 0);

        // write region 1, one wait state
        req = 1'b1; addr = 32'h0000_1004; we = 1'b1; wdata = 8'h3C;
        @(negedge clk);
        chk("wr1_sel_c1", s_sel, 2'b10);
        chk("wr1_saddr_c1", s_addr, 32'h4);
        chk("wr1_swdata", s_wdata, 8'h3C);
        chk("wr1_swe_c1", s_we, 0);
        addr = 32'h0000_0000; wdata = 8'hFF; we = 1'b0;
        @(negedge clk);
        chk("wr1_sel_c2", s_sel, 2'b10);
        chk("wr1_saddr_c2", s_addr, 32'h4);
        chk("wr1_swe_c2", s_we, 1);
        chk("wr1_swdata_c2", s_wdata, 8'h3C);
        @(negedge clk);
        chk("wr1_ready", ready, 1);
        chk("wr1_swe_c3", s_we, 0);
        chk("wr1_rdata_hold", rdata, 8'hA5);
        req = 1'b0;
        @(negedge clk);

        // unmapped
        access(32'h0000_2000, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("unm_lat", lat, 1);
        chk("unm_fault", flt, 1);
        chk("unm_rdata", rd, 0);
        chk("unm_sel", sel1, 0);
        chk("unm_we", wcnt, 0);
`ifdef MEM_BUS_FAULT_LOG_EN
        chk("unm_faddr", fault_addr, 32'h2000);
        chk("unm_fcnt", fault_count, 1);
`endif

        // window boundaries
        access(32'h0000_0FFF, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("b0fff_sel", sel1, 2'b01);
        chk("b0fff_saddr", sa1, 32'hFFF);
        chk("b0fff_lat", lat, 2);
        access(32'h0000_1000, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("b1000_sel", sel1, 2'b10);
        chk("b1000_saddr", sa1, 32'h0);
        chk("b1000_lat", lat, 3);
        chk("b1000_rdata", rd, 8'h5A);
        access(32'h0000_1FFF, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("b1fff_sel", sel1, 2'b10);
        chk("b1fff_saddr", sa1, 32'hFFF);
        chk("b1fff_fault", flt, 0);
        access(32'hFFFF_FFFF, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("bffff_lat", lat, 1);
        chk("bffff_fault", flt, 1);
`ifdef MEM_BUS_FAULT_LOG_EN
        chk("bffff_faddr", fault_addr, 32'hFFFF_FFFF);
        chk("bffff_fcnt", fault_count, 2);
`endif

        // overlapping map: identical bases pick region 0
        req_o = 1'b1; addr_o = 32'h0000_0020;
        @(negedge clk);
        chk("ovl_sel", s_sel_o, 2'b01);
        chk("ovl_saddr", s_addr_o, 32'h20);
        req_o = 1'b0;
        repeat (2) @(negedge clk);
        chk("ovl_idle_sel", s_sel_o, 0);

        // reset during a write before its strobe
        req = 1'b1; addr = 32'h0000_1008; we = 1'b1; wdata = 8'h77;
        @(negedge clk);
        chk("mr_swe_pre", s_we, 0);
        chk("mr_sel_pre", s_sel, 2'b10);
        rst = 1'b0;
        #1;
        chk("mr_sel", s_sel, 0);
        chk("mr_saddr", s_addr, 0);
        chk("mr_swdata", s_wdata, 0);
        chk("mr_swe", s_we, 0);
        chk("mr_ready", ready, 0);
        chk("mr_rdata", rdata, 0);
        req = 1'b0; we = 1'b0;
        wcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (s_we) wcnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        if (s_we) wcnt++;
        chk("mr_we_never", wcnt, 0);
        access(32'h0000_0010, 1'b0, 8'h00, lat, sel1, sa1, flt, rd, wcnt, wcyc);
        chk("mr_after_lat", lat, 2);
        chk("mr_after_rdata", rd, 8'hA5);

        // back-to-back reads with req held
        req = 1'b1; addr = 32'h0000_0010; we = 1'b0;
        nrdy = 0; t1 = -1; t2 = -1; wcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (s_we) wcnt++;
            if (ready) begin
                nrdy++;
                if (nrdy == 1) t1 = c;
                if (nrdy == 2) begin
                    t2 = c;
                    req = 1'b0;
                    break;
                end
            end
        end
        req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ready) nrdy++;
            if (s_we) wcnt++;
        end
        chk("b2b_t1", t1, 2);
        chk("b2b_t2", t2, 5);
        chk("b2b_nrdy", nrdy, 2);
        chk("b2b_we", wcnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Parametrised CPU-to-memory bus decoder with a registered request/ready handshake.
- Replaces the flat combinational ROM/RAM select at SoC top level.
- Maps NUM_REGIONS address windows onto slave ports. Each region has its own programmable wait states.
- Returns a one-cycle fault response for unmapped addresses.
- Sits between cpu and the memory/peripheral slaves in the SoC top.

Parameters:
- NUM_REGIONS, 2, number of slave windows (1..8).
- ADDR_W, 32, CPU address width.
- DATA_W, 8, data bus width.
- WAIT_W, 4, width of each per-region wait-state field.
- REGION_BASE, {32'h0000_1000, 32'h0000_0000}, packed NUM_REGIONS*ADDR_W base addresses; region i occupies slice i.
- REGION_SIZE, {32'h0000_1000, 32'h0000_1000}, packed sizes in bytes. Size 0 disables the region.
- REGION_WAIT, {4'd1, 4'd0}, packed wait states per region.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  CPU access request.
- addr  in  ADDR_W  CPU byte address.
- we  in  1  1 = write, 0 = read.
- wdata  in  DATA_W  CPU write data.
- rdata  out  DATA_W  read data, valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- fault  out  1  qualifies ready: access hit no region.
- s_sel  out  NUM_REGIONS  one-hot slave select.
- s_addr  out  ADDR_W  offset address (addr - base), shared by all slaves.
- s_we  out  1  one-cycle write strobe, shared by all slaves.
- s_wdata  out  DATA_W  write data, shared by all slaves.
- s_rdata  in  NUM_REGIONS*DATA_W  slave read data, slice i from slave i.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. rdata, ready, fault, s_sel, s_addr, s_we, s_wdata all 0. An in-flight write is aborted and s_we drops immediately.
- Decode (combinational, IDLE only): region i hits when base_i <= addr < base_i + size_i.
  - Compare unsigned, in ADDR_W+1 bits, so base+size may equal 2^ADDR_W without wrap.
  - Overlapping hits: lowest index wins.
- FSM states: IDLE, ACCESS, RESP, FAULT.
- IDLE, req=1, hit i: latch i, offset, we and wdata. Load wait counter with REGION_WAIT[i]. Go to ACCESS.
- IDLE, req=1, no hit: go to FAULT.
- ACCESS:
  - s_sel[i]=1, s_addr=offset, s_wdata=latched data.
  - Counter decrements each cycle.
  - When counter==0: s_we=latched we for exactly this cycle; register s_rdata slice i into rdata (reads only); next state RESP.
- RESP: ready=1 for one cycle, fault=0, s_sel=0. Next state IDLE.
- FAULT: ready=1, fault=1, rdata=0 for one cycle. No slave is selected and no write occurs. Next state IDLE.
- Latency, req sampled at edge k:
  - Hit, W wait states: ready high during cycle k+W+2.
  - Fault: ready high during cycle k+1.
- Handshake:
  - CPU holds req until ready. Changes on addr/we/wdata after acceptance are ignored.
  - req sampled in RESP/FAULT is ignored. A new access is accepted only in IDLE, so back-to-back throughput is one access per W+3 cycles.
- On writes, rdata holds its previous value.

Optional Feature:
- Macro: MEM_BUS_FAULT_LOG_EN.
- Defined: adds output fault_addr (ADDR_W) and output fault_count (16).
  - On entry to FAULT: fault_addr <= addr; fault_count increments, saturating at 16'hFFFF.
  - Both cleared only by reset.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package bus_pkg holds:
  - the state enum (IDLE/ACCESS/RESP/FAULT, 2-bit encoding);
  - the REGION_IDX_W = clog2(NUM_REGIONS) helper;
  - default map constants (ROM_BASE, RAM_BASE, sizes).
- One sub-module: addr_region_match.
  - Combinational; one instance per region via generate.
  - Inputs: addr, base, size. Outputs: hit, offset.
  - The priority encoder stays in mem_bus_decoder.

Test Plan:
- Read region 0 (wait 0): addr=0x0000_0010, s_rdata0=0xA5 → s_sel=01 and s_addr=0x10 one cycle after acceptance; ready with rdata=0xA5 at k+2; fault=0.
- Write region 1 (wait 1): addr=0x0000_1004, wdata=0x3C → s_sel=10, s_addr=0x4 for 2 cycles; s_we high only on the second cycle; ready at k+3.
- Unmapped read at addr=0x0000_2000 → ready=1, fault=1, rdata=0 at k+1; s_sel stays 0; s_we never asserts. With MEM_BUS_FAULT_LOG_EN: fault_addr=0x2000, fault_count=1.
- Boundaries: 0x0000_0FFF hits region 0; 0x0000_1000 hits region 1; 0x0000_1FFF hits region 1; 0xFFFF_FFFF faults. An overlapping map with identical bases selects region 0.
- Reset mid-access: drive rst=0 during a write's ACCESS cycle, before the strobe → s_we never pulses, all outputs 0 asynchronously; the next request after reset release completes normally.
- Back-to-back: hold req=1 across two reads → second acceptance only after the RESP cycle; exactly two ready pulses; no duplicate write strobes.
